// File: rtl/adder_sub_unit.sv
// adder_sub_unit: WIDTH-bit two's-complement add (cin=0) / subtract (cin=1) with CLA_BLOCK lookahead groups.
// Define ADDER_SUB_OUT_REG_EN to register sum/cout/ovf for one cycle of latency; otherwise purely combinational.
module adder_sub_unit #(
  parameter int WIDTH     = 32,
  parameter int CLA_BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / CLA_BLOCK;
  if (WIDTH < 4 || WIDTH % CLA_BLOCK != 0) begin : g_bad_params
    $error("adder_sub_unit: WIDTH must be >= 4 and a multiple of CLA_BLOCK");
  end
  logic [WIDTH-1:0] w_b_eff, w_g, w_p, w_sum;
  logic [WIDTH:0]   w_c;
  logic             w_cout, w_ovf, w_t, w_acc;
  assign w_b_eff = b ^ {WIDTH{cin}};
  assign w_g     = a & w_b_eff;
  assign w_p     = a ^ w_b_eff;
  // Each carry inside a group is a flat sum-of-products of the group's g/p and its carry-in;
  // only the group carry-outs ripple from one group to the next.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    w_t    = 1'b0;
    w_acc  = 1'b0;
    for (int n = 0; n < NG; n++) begin
      for (int j = 1; j <= CLA_BLOCK; j++) begin
        w_t = w_c[n*CLA_BLOCK];
        for (int m = 0; m < j; m++) w_t = w_t & w_p[n*CLA_BLOCK+m];
        w_acc = w_t;
        for (int k = 0; k < j; k++) begin
          w_t = w_g[n*CLA_BLOCK+k];
          for (int m = k + 1; m < j; m++) w_t = w_t & w_p[n*CLA_BLOCK+m];
          w_acc = w_acc | w_t;
        end
        w_c[n*CLA_BLOCK+j] = w_acc;
      end
    end
  end
  assign w_sum  = w_p ^ w_c[WIDTH-1:0];
  assign w_cout = w_c[WIDTH];
  assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
`ifdef ADDER_SUB_OUT_REG_EN
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
`else
  logic w_unused;
  assign w_unused = clk ^ rst;
  assign sum  = w_sum;
  assign cout = w_cout;
  assign ovf  = w_ovf;
`endif
endmodule

// File: tb/tb_adder_sub_unit.sv
// tb_adder_sub_unit: directed table, reset sequences and a random sweep against a signed/unsigned arithmetic model.
// Works for both the combinational build and the ADDER_SUB_OUT_REG_EN build.
module tb_adder_sub_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [31:0] sum;
  logic        cout, ovf;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;
  vec_t tbl[7];

  adder_sub_unit #(.WIDTH(32), .CLA_BLOCK(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                                output logic [31:0] s, output logic co, output logic ov);
    longint sa, sb, r, ua, ub;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = longint'({32'b0, ma});
    ub = longint'({32'b0, mb});
    r  = mc ? sa - sb : sa + sb;
    s  = r[31:0];
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    co = mc ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
  endfunction

  task automatic check(input string name, input logic [31:0] es, input logic ec, input logic eo);
    n_checks++;
    if (sum !== es || cout !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, es, ec, eo);
    end
  endtask

  task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic vc);
    a = va; b = vb; cin = vc;
`ifdef ADDER_SUB_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    logic [31:0] es;
    logic        ec, eo;
    tbl[0] = '{"add_5_3",      32'h5,        32'h3,        1'b0, 32'h8,        1'b0, 1'b0};
    tbl[1] = '{"sub_5_3",      32'h5,        32'h3,        1'b1, 32'h2,        1'b1, 1'b0};
    tbl[2] = '{"sub_3_5",      32'h3,        32'h5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{"wrap_ones_p1", 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0};
    tbl[4] = '{"ovf_pos",      32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[5] = '{"ovf_neg",      32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[6] = '{"a_minus_a",    32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b0};

    a = 32'h5; b = 32'h3; cin = 1'b0;
    #2;
`ifdef ADDER_SUB_OUT_REG_EN
    check("reset_state", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 1'b0, 1'b0);
`else
    check("reset_no_effect", 32'h8, 1'b0, 1'b0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].cin);
      check(tbl[i].name, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
    end

    apply(32'h0, 32'h1, 1'b1);
    check("zero_minus_one", 32'hFFFFFFFF, 1'b0, 1'b0);

`ifdef ADDER_SUB_OUT_REG_EN
    apply(32'h10, 32'h01, 1'b0);
    check("reg_latency", 32'h11, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'h0, 1'b0, 1'b0);
    a = 32'h7FFFFFFF; b = 32'h1; cin = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("release_no_edge", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("release_first_edge", 32'h80000000, 1'b0, 1'b1);
`else
    a = 32'h10; b = 32'h01; cin = 1'b0;
    rst = 1'b1;
    #1;
    check("comb_rst_high", 32'h11, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("comb_rst_low", 32'h11, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra, rb;
      logic        rc;
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      apply(ra, rb, rc);
      model(ra, rb, rc, es, ec, eo);
      check("random", es, ec, eo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
